// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_rd_arbiter
// Purpose  : Shares one AXI read slave between two read masters (M0, M1).
//            Round-robin AR arbitration, one burst outstanding, R beats
//            routed combinationally to the granted master until r_last.
// Config   : RD_ARB_FIXED_PRIO_EN - when defined, M0 always wins a
//            simultaneous request (last_gnt tracked but ignored).
// Revision : 1.0 - initial release
// ============================================================================
module axi_rd_arbiter #(
  parameter int ADDR_BITS = 32,
  parameter int LEN_BITS  = 8,
  parameter int SIZE_BITS = 3,
  parameter int DATA_BITS = 32
) (
  input  logic                 aclk,
  input  logic                 areset_n,
  // master 0
  input  logic                 m0_ar_valid,
  output logic                 m0_ar_ready,
  input  logic [ADDR_BITS-1:0] m0_ar_addr,
  input  logic [LEN_BITS-1:0]  m0_ar_len,
  input  logic [SIZE_BITS-1:0] m0_ar_size,
  input  logic [1:0]           m0_ar_burst,
  input  logic [3:0]           m0_ar_cache,
  output logic                 m0_r_valid,
  input  logic                 m0_r_ready,
  output logic [DATA_BITS-1:0] m0_r_data,
  output logic [1:0]           m0_r_resp,
  output logic                 m0_r_last,
  // master 1
  input  logic                 m1_ar_valid,
  output logic                 m1_ar_ready,
  input  logic [ADDR_BITS-1:0] m1_ar_addr,
  input  logic [LEN_BITS-1:0]  m1_ar_len,
  input  logic [SIZE_BITS-1:0] m1_ar_size,
  input  logic [1:0]           m1_ar_burst,
  input  logic [3:0]           m1_ar_cache,
  output logic                 m1_r_valid,
  input  logic                 m1_r_ready,
  output logic [DATA_BITS-1:0] m1_r_data,
  output logic [1:0]           m1_r_resp,
  output logic                 m1_r_last,
  // slave
  output logic                 s_ar_valid,
  input  logic                 s_ar_ready,
  output logic [ADDR_BITS-1:0] s_ar_addr,
  output logic [LEN_BITS-1:0]  s_ar_len,
  output logic [SIZE_BITS-1:0] s_ar_size,
  output logic [1:0]           s_ar_burst,
  output logic [3:0]           s_ar_cache,
  input  logic                 s_r_valid,
  output logic                 s_r_ready,
  input  logic [DATA_BITS-1:0] s_r_data,
  input  logic [1:0]           s_r_resp,
  input  logic                 s_r_last
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [1:0]           state_q, state_d;
  logic                 gnt_q, gnt_d;
  logic                 last_gnt_q, last_gnt_d;
  logic [ADDR_BITS-1:0] ar_addr_q, ar_addr_d;
  logic [LEN_BITS-1:0]  ar_len_q, ar_len_d;
  logic [SIZE_BITS-1:0] ar_size_q, ar_size_d;
  logic [1:0]           ar_burst_q, ar_burst_d;
  logic [3:0]           ar_cache_q, ar_cache_d;

  logic w_any_req;
  logic w_winner;
  logic w_idle;
  logic w_data_to_m0;
  logic w_data_to_m1;

  assign w_any_req = m0_ar_valid | m1_ar_valid;
  assign w_idle    = (state_q == ST_IDLE);

  // Pick the winner: sole requester, otherwise the arbitration policy.
  always_comb begin
    w_winner = 1'b0;
    if (m1_ar_valid && !m0_ar_valid) begin
      w_winner = 1'b1;
    end else if (m0_ar_valid && m1_ar_valid) begin
`ifdef RD_ARB_FIXED_PRIO_EN
      w_winner = 1'b0;
`else
      w_winner = ~last_gnt_q;
`endif
    end
  end

  // Next-state, grant and AR payload capture.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    ar_addr_d  = ar_addr_q;
    ar_len_d   = ar_len_q;
    ar_size_d  = ar_size_q;
    ar_burst_d = ar_burst_q;
    ar_cache_d = ar_cache_q;
    case (state_q)
      ST_IDLE: begin
        if (w_any_req) begin
          state_d    = ST_ADDR;
          gnt_d      = w_winner;
          last_gnt_d = w_winner;
          ar_addr_d  = w_winner ? m1_ar_addr  : m0_ar_addr;
          ar_len_d   = w_winner ? m1_ar_len   : m0_ar_len;
          ar_size_d  = w_winner ? m1_ar_size  : m0_ar_size;
          ar_burst_d = w_winner ? m1_ar_burst : m0_ar_burst;
          ar_cache_d = w_winner ? m1_ar_cache : m0_ar_cache;
        end
      end
      ST_ADDR: begin
        if (s_ar_ready) state_d = ST_DATA;
      end
      ST_DATA: begin
        // Burst end is taken from r_last only; ar_len is not tracked.
        if (s_r_valid && s_r_ready && s_r_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and payload registers; reset leaves M0 as first winner.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q    <= ST_IDLE;
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      ar_cache_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      ar_addr_q  <= ar_addr_d;
      ar_len_q   <= ar_len_d;
      ar_size_q  <= ar_size_d;
      ar_burst_q <= ar_burst_d;
      ar_cache_q <= ar_cache_d;
    end
  end

  // AR side: accept pulse in IDLE (held off while in reset), registered request out.
  assign m0_ar_ready = areset_n & w_idle & w_any_req & ~w_winner;
  assign m1_ar_ready = areset_n & w_idle & w_any_req &  w_winner;
  assign s_ar_valid  = (state_q == ST_ADDR);
  assign s_ar_addr   = ar_addr_q;
  assign s_ar_len    = ar_len_q;
  assign s_ar_size   = ar_size_q;
  assign s_ar_burst  = ar_burst_q;
  assign s_ar_cache  = ar_cache_q;

  // R side: zero-latency pass-through to the granted master only.
  assign w_data_to_m0 = (state_q == ST_DATA) & ~gnt_q;
  assign w_data_to_m1 = (state_q == ST_DATA) &  gnt_q;

  assign m0_r_valid = w_data_to_m0 & s_r_valid;
  assign m0_r_data  = w_data_to_m0 ? s_r_data : '0;
  assign m0_r_resp  = w_data_to_m0 ? s_r_resp : 2'b00;
  assign m0_r_last  = w_data_to_m0 & s_r_last;

  assign m1_r_valid = w_data_to_m1 & s_r_valid;
  assign m1_r_data  = w_data_to_m1 ? s_r_data : '0;
  assign m1_r_resp  = w_data_to_m1 ? s_r_resp : 2'b00;
  assign m1_r_last  = w_data_to_m1 & s_r_last;

  // Outside DATA the slave is stalled so stray beats are never lost.
  assign s_r_ready = (w_data_to_m0 & m0_r_ready) | (w_data_to_m1 & m1_r_ready);

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_rd_arbiter
// Purpose  : Self-checking bench for axi_rd_arbiter with a grant-order
//            reference model and randomized bursts/backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_rd_arbiter;

  logic        aclk = 1'b0;
  logic        areset_n;
  logic        m0_ar_valid, m0_ar_ready, m1_ar_valid, m1_ar_ready;
  logic [31:0] m0_ar_addr, m1_ar_addr, s_ar_addr;
  logic [7:0]  m0_ar_len, m1_ar_len, s_ar_len;
  logic [2:0]  m0_ar_size, m1_ar_size, s_ar_size;
  logic [1:0]  m0_ar_burst, m1_ar_burst, s_ar_burst;
  logic [3:0]  m0_ar_cache, m1_ar_cache, s_ar_cache;
  logic        m0_r_valid, m0_r_ready, m0_r_last, m1_r_valid, m1_r_ready, m1_r_last;
  logic [31:0] m0_r_data, m1_r_data, s_r_data;
  logic [1:0]  m0_r_resp, m1_r_resp, s_r_resp;
  logic        s_ar_valid, s_ar_ready, s_r_valid, s_r_ready, s_r_last;

  int tests = 0;
  int fails = 0;
  int model_last = 1;   // reference: who was granted last (reset -> 1)

  axi_rd_arbiter dut (
    .aclk(aclk), .areset_n(areset_n),
    .m0_ar_valid(m0_ar_valid), .m0_ar_ready(m0_ar_ready), .m0_ar_addr(m0_ar_addr),
    .m0_ar_len(m0_ar_len), .m0_ar_size(m0_ar_size), .m0_ar_burst(m0_ar_burst),
    .m0_ar_cache(m0_ar_cache), .m0_r_valid(m0_r_valid), .m0_r_ready(m0_r_ready),
    .m0_r_data(m0_r_data), .m0_r_resp(m0_r_resp), .m0_r_last(m0_r_last),
    .m1_ar_valid(m1_ar_valid), .m1_ar_ready(m1_ar_ready), .m1_ar_addr(m1_ar_addr),
    .m1_ar_len(m1_ar_len), .m1_ar_size(m1_ar_size), .m1_ar_burst(m1_ar_burst),
    .m1_ar_cache(m1_ar_cache), .m1_r_valid(m1_r_valid), .m1_r_ready(m1_r_ready),
    .m1_r_data(m1_r_data), .m1_r_resp(m1_r_resp), .m1_r_last(m1_r_last),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr),
    .s_ar_len(s_ar_len), .s_ar_size(s_ar_size), .s_ar_burst(s_ar_burst),
    .s_ar_cache(s_ar_cache), .s_r_valid(s_r_valid), .s_r_ready(s_r_ready),
    .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_last(s_r_last)
  );

  always #5 aclk = ~aclk;

  // Reference arbitration rule.
  function automatic int model_winner(input bit r0, input bit r1);
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
`ifdef RD_ARB_FIXED_PRIO_EN
    return 0;
`else
    return (model_last == 0) ? 1 : 0;
`endif
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic rand_payload(input int m, input int len);
    if (m == 0) begin
      m0_ar_addr = $urandom; m0_ar_len = len[7:0]; m0_ar_size = 3'($urandom);
      m0_ar_burst = 2'($urandom); m0_ar_cache = 4'($urandom);
    end else begin
      m1_ar_addr = $urandom; m1_ar_len = len[7:0]; m1_ar_size = 3'($urandom);
      m1_ar_burst = 2'($urandom); m1_ar_cache = 4'($urandom);
    end
  endtask

  task automatic set_valid(input int m, input logic v);
    if (m == 0) m0_ar_valid = v; else m1_ar_valid = v;
  endtask

  task automatic do_reset();
    areset_n = 1'b0;
    m0_ar_valid = 0; m1_ar_valid = 0; m0_r_ready = 0; m1_r_ready = 0;
    s_ar_ready = 0; s_r_valid = 0; s_r_data = 0; s_r_resp = 0; s_r_last = 0;
    rand_payload(0, 0); rand_payload(1, 0);
    repeat (3) @(posedge aclk);
    #1 areset_n = 1'b1;
    model_last = 1;
  endtask

  // Drives one burst through the DUT and reports what was observed.
  // errs counts protocol/routing deviations seen along the way.
  task automatic run_burst(input int len, input int ar_stall, input int bp_at,
                           input int bp_cycles, input bit rand_bp, input int raise_other_at,
                           input bit drop_valid, output int winner, output int errs,
                           output int beats);
    logic [31:0] e_addr; logic [7:0] e_len; logic [2:0] e_size;
    logic [1:0]  e_burst; logic [3:0] e_cache;
    logic [31:0] data; logic [1:0] resp;
    int budget; int bp_left; int other; bit rdy;
    winner = -1; errs = 0; beats = 0; budget = 0; bp_left = bp_cycles;
    e_addr = 0; e_len = 0; e_size = 0; e_burst = 0; e_cache = 0;
    while (winner < 0 && budget < 50) begin
      @(negedge aclk);
      if (m0_ar_ready && m1_ar_ready) errs++;
      if (m0_ar_ready) winner = 0;
      else if (m1_ar_ready) winner = 1;
      if (winner == 0) begin
        e_addr = m0_ar_addr; e_len = m0_ar_len; e_size = m0_ar_size;
        e_burst = m0_ar_burst; e_cache = m0_ar_cache;
      end else if (winner == 1) begin
        e_addr = m1_ar_addr; e_len = m1_ar_len; e_size = m1_ar_size;
        e_burst = m1_ar_burst; e_cache = m1_ar_cache;
      end
      tick();
      budget++;
    end
    if (winner < 0) return;
    other = 1 - winner;
    if (drop_valid) set_valid(winner, 1'b0);
    rand_payload(winner, $urandom_range(0, 7));  // latch must not follow
    // ADDR phase with a stray slave beat that must stall.
    data = $urandom; resp = 2'($urandom);
    s_r_valid = 1; s_r_data = data; s_r_resp = resp; s_r_last = (len == 0);
    m0_r_ready = 1; m1_r_ready = 1;
    for (int c = 0; c <= ar_stall; c++) begin
      s_ar_ready = (c == ar_stall);
      @(negedge aclk);
      if (s_ar_valid !== 1'b1 || s_ar_addr !== e_addr || s_ar_len !== e_len ||
          s_ar_size !== e_size || s_ar_burst !== e_burst || s_ar_cache !== e_cache) errs++;
      if (m0_ar_ready !== 1'b0 || m1_ar_ready !== 1'b0) errs++;
      if (s_r_ready !== 1'b0 || m0_r_valid !== 1'b0 || m1_r_valid !== 1'b0) errs++;
      tick();
    end
    s_ar_ready = 0;
    budget = 0;
    while (beats <= len && budget < 200) begin
      if (beats == raise_other_at) set_valid(other, 1'b1);
      if (beats == bp_at && bp_left > 0) begin rdy = 0; bp_left--; end
      else if (rand_bp) rdy = ($urandom_range(0, 3) != 0);
      else rdy = 1;
      if (winner == 0) begin m0_r_ready = rdy; m1_r_ready = 1'($urandom); end
      else begin m1_r_ready = rdy; m0_r_ready = 1'($urandom); end
      s_r_valid = 1; s_r_data = data; s_r_resp = resp; s_r_last = (beats == len);
      @(negedge aclk);
      if (winner == 0) begin
        if (m0_r_valid !== 1'b1 || m0_r_data !== data || m0_r_resp !== resp ||
            m0_r_last !== s_r_last) errs++;
        if (m1_r_valid !== 1'b0 || m1_r_data !== 32'h0 || m1_r_last !== 1'b0) errs++;
      end else begin
        if (m1_r_valid !== 1'b1 || m1_r_data !== data || m1_r_resp !== resp ||
            m1_r_last !== s_r_last) errs++;
        if (m0_r_valid !== 1'b0 || m0_r_data !== 32'h0 || m0_r_last !== 1'b0) errs++;
      end
      if (s_r_ready !== rdy) errs++;
      if (s_ar_valid !== 1'b0 || m0_ar_ready !== 1'b0 || m1_ar_ready !== 1'b0) errs++;
      tick();
      if (rdy) begin beats++; data = $urandom; resp = 2'($urandom); end
      budget++;
    end
    s_r_valid = 0; s_r_last = 0; m0_r_ready = 0; m1_r_ready = 0;
  endtask

  task automatic test_reset();
    areset_n = 1'b0;
    m0_ar_valid = 1; m1_ar_valid = 1;
    @(negedge aclk);
    tests++;
    if ({m0_ar_ready, m1_ar_ready, s_ar_valid, s_r_ready, m0_r_valid, m1_r_valid} !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b required 000000",
               {m0_ar_ready, m1_ar_ready, s_ar_valid, s_r_ready, m0_r_valid, m1_r_valid});
    end
    tests++;
    if (s_ar_addr !== 32'h0 || s_ar_len !== 8'h0 || s_ar_cache !== 4'h0) begin
      fails++;
      $display("FAIL reset_payload: addr=%h len=%h required 0", s_ar_addr, s_ar_len);
    end
    @(posedge aclk);
    #1 areset_n = 1'b1;
    @(negedge aclk);
    tests++;
    if (m0_ar_ready !== 1'b1 || m1_ar_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_first_grant: m0=%b m1=%b required m0=1 m1=0", m0_ar_ready, m1_ar_ready);
    end
    m0_ar_valid = 0; m1_ar_valid = 0;  // withdraw before the edge
    do_reset();
  endtask

  task automatic test_single_burst();
    int w, e, b;
    m0_ar_addr = 32'h100; m0_ar_len = 8'd3; m0_ar_valid = 1;
    run_burst(3, 0, -1, 0, 0, -1, 1, w, e, b);
    tests++;
    if (w !== 0 || e !== 0 || b !== 4) begin
      fails++;
      $display("FAIL single_burst: winner=%0d errs=%0d beats=%0d required 0/0/4", w, e, b);
    end
    model_last = 0;
  endtask

  task automatic test_round_robin();
    int w, e, b, exp;
    do_reset();
    m0_ar_valid = 1; m1_ar_valid = 1;
    for (int i = 0; i < 4; i++) begin
      exp = model_winner(1, 1);
      run_burst(0, 0, -1, 0, 0, -1, 0, w, e, b);
      tests++;
      if (w !== exp || e !== 0 || b !== 1) begin
        fails++;
        $display("FAIL round_robin[%0d]: winner=%0d errs=%0d beats=%0d required %0d/0/1",
                 i, w, e, b, exp);
      end
      model_last = exp;
    end
    m0_ar_valid = 0; m1_ar_valid = 0;
  endtask

  task automatic test_backpressure();
    int w, e, b;
    do_reset();
    rand_payload(1, 3); m1_ar_valid = 1;
    run_burst(3, 0, 1, 3, 0, -1, 1, w, e, b);
    tests++;
    if (w !== 1 || e !== 0 || b !== 4) begin
      fails++;
      $display("FAIL backpressure: winner=%0d errs=%0d beats=%0d required 1/0/4", w, e, b);
    end
    model_last = 1;
  endtask

  task automatic test_ar_stall();
    int w, e, b, exp;
    rand_payload(0, 1); rand_payload(1, 1);
    m0_ar_valid = 1; m1_ar_valid = 1;
    exp = model_winner(1, 1);
    run_burst(1, 5, -1, 0, 0, -1, 1, w, e, b);
    tests++;
    if (w !== exp || e !== 0 || b !== 2) begin
      fails++;
      $display("FAIL ar_stall: winner=%0d errs=%0d beats=%0d required %0d/0/2", w, e, b, exp);
    end
    model_last = exp;
    exp = 1 - exp;  // only the loser is still requesting
    run_burst(0, 0, -1, 0, 0, -1, 1, w, e, b);
    tests++;
    if (w !== exp || e !== 0 || b !== 1) begin
      fails++;
      $display("FAIL ar_stall_next: winner=%0d errs=%0d beats=%0d required %0d/0/1", w, e, b, exp);
    end
    model_last = exp;
  endtask

  task automatic test_request_during_data();
    int w, e, b;
    do_reset();
    rand_payload(0, 3); m0_ar_valid = 1;
    run_burst(3, 0, -1, 0, 0, 1, 1, w, e, b);
    tests++;
    if (w !== 0 || e !== 0 || b !== 4) begin
      fails++;
      $display("FAIL req_during_data: winner=%0d errs=%0d beats=%0d required 0/0/4", w, e, b);
    end
    @(negedge aclk);
    tests++;
    if (m1_ar_ready !== 1'b1 || m0_ar_ready !== 1'b0) begin
      fails++;
      $display("FAIL req_after_last: m1_ar_ready=%b m0_ar_ready=%b required 1/0",
               m1_ar_ready, m0_ar_ready);
    end
    m1_ar_valid = 0;
    do_reset();
  endtask

  task automatic test_reset_mid_burst();
    rand_payload(0, 7); m0_ar_valid = 1;
    @(negedge aclk);
    tick();
    m0_ar_valid = 0; s_ar_ready = 1;
    tick();
    s_ar_ready = 0; s_r_valid = 1; s_r_data = 32'hA5A5_0001; s_r_last = 0; m0_r_ready = 1;
    tick();
    s_r_data = 32'hA5A5_0002; m0_ar_valid = 1; m1_ar_valid = 1;
    @(negedge aclk);
    tests++;
    if (m0_r_valid !== 1'b1 || m0_r_data !== 32'hA5A5_0002) begin
      fails++;
      $display("FAIL mid_burst_beat2: valid=%b data=%h required 1/a5a50002", m0_r_valid, m0_r_data);
    end
    #2 areset_n = 1'b0;
    #1;
    tests++;
    if ({m0_ar_ready, m1_ar_ready, s_ar_valid, s_r_ready, m0_r_valid, m1_r_valid} !== 6'b0 ||
        m0_r_data !== 32'h0 || s_ar_addr !== 32'h0 || s_ar_len !== 8'h0) begin
      fails++;
      $display("FAIL async_reset: ctrl=%b data=%h addr=%h required all 0",
               {m0_ar_ready, m1_ar_ready, s_ar_valid, s_r_ready, m0_r_valid, m1_r_valid},
               m0_r_data, s_ar_addr);
    end
    s_r_valid = 0; m0_r_ready = 0;
    @(posedge aclk);
    #1 areset_n = 1'b1;
    @(negedge aclk);
    tests++;
    if (m0_ar_ready !== 1'b1 || m1_ar_ready !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_grant: m0=%b m1=%b required 1/0", m0_ar_ready, m1_ar_ready);
    end
    m0_ar_valid = 0; m1_ar_valid = 0;
    do_reset();
  endtask

  task automatic test_random();
    int w, e, b, exp, len;
    bit r0, r1;
    for (int i = 0; i < 40; i++) begin
      r0 = 1'($urandom); r1 = 1'($urandom);
      if (!r0 && !r1) r1 = 1;
      len = $urandom_range(0, 3);
      rand_payload(0, len); rand_payload(1, len);
      m0_ar_valid = r0; m1_ar_valid = r1;
      exp = model_winner(r0, r1);
      run_burst(len, $urandom_range(0, 2), -1, 0, 1, -1, 1, w, e, b);
      tests++;
      if (w !== exp || e !== 0 || b !== len + 1) begin
        fails++;
        $display("FAIL random[%0d]: winner=%0d errs=%0d beats=%0d required %0d/0/%0d",
                 i, w, e, b, exp, len + 1);
      end
      model_last = exp;
      m0_ar_valid = 0; m1_ar_valid = 0;
    end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_single_burst();
    test_round_robin();
    test_backpressure();
    test_ar_stall();
    test_request_during_data();
    test_reset_mid_burst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
